conv_window_buffer: RTL
=======================

# conv_window_buffer

Line-buffer window generator feeding the 3x3 convolution MAC. Accepts a raster-order stream of 16-bit signed pixels and emits every fully-populated 3x3 window ("valid" convolution, no padding) as a packed 144-bit word in the MAC's `ifmap_chunk` layout. Also produces a valid strobe delayed to match the MAC's fixed 3-cycle latency, so the consumer can qualify `mac_output` directly.

## Interface
- `PIX_BITS`, 16: pixel width; fixed at 16 so the window is 9*16 = 144 bits.
- `IMG_W`, 28: image width in pixels, at least 3.
- `IMG_H`, 28: image height in pixels, at least 3.
- `MAC_LAT`, 3: downstream MAC pipeline depth in cycles.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pix_in`  in  16  signed input pixel.
- `pix_valid`  in  1  `pix_in` is accepted on this edge.
- `sof`  in  1  start-of-frame marker, qualified by `pix_valid`.
- `win_data`  out  144  3x3 window: [143:128]=(r-2,c-2), [127:112]=(r-2,c-1), [111:96]=(r-2,c), [95:80]=(r-1,c-2), [79:64]=(r-1,c-1), [63:48]=(r-1,c), [47:32]=(r,c-2), [31:16]=(r,c-1), [15:0]=(r,c).
- `win_valid`  out  1  one-cycle pulse; `win_data` holds a new window.
- `win_last`  out  1  pulse coincident with the window centred on the frame's last pixel.
- `mac_valid`  out  1  `win_valid` delayed `MAC_LAT` cycles.
- `mac_last`  out  1  `win_last` delayed `MAC_LAT` cycles.
- `frame_err`  out  1  one-cycle pulse on a resynchronisation (see Configuration).

## Operation
- Column counter `col` ranges 0..IMG_W-1 and row counter `row` ranges 0..IMG_H-1, width $clog2 of each. Both advance only on an accepted pixel. `col` wraps to 0 and increments `row`; after (IMG_H-1, IMG_W-1) both return to 0 for the next frame.
- Two line buffers, each IMG_W deep and read-before-write at index `col`:
  - LB1 holds row r-1. On each accepted pixel, its old entry at `col` is written into LB2 and `pix_in` is written into LB1.
  - LB2 holds row r-2.
- Window register: 3 columns of 3 pixels. On each accepted pixel, the columns shift left and the new right column is {LB2[col], LB1[col], `pix_in`}.
- A window is valid when the accepted pixel has `row`>=2 and `col`>=2. This gives (IMG_W-2)*(IMG_H-2) windows per frame (676 at default). No window ever spans a row or frame boundary.
- There is no backpressure. The MAC accepts every cycle. Gaps in `pix_valid` of any length are legal; state and `win_data` hold during gaps.
- Arithmetic: the block does not modify pixel values; bits pass through unchanged.

## Timing
- Window latency: 1 cycle. A pixel accepted at edge t produces `win_data`/`win_valid` (if the window is valid) at t+1. `win_data` is stable until the next accepted pixel.
- `mac_valid`/`mac_last` are a `MAC_LAT`-stage shift of `win_valid`/`win_last`, so `mac_valid` is high exactly in the cycle the MAC's `mac_output` is valid.
- Reset values: `win_data`=0, `win_valid`=0, `win_last`=0, `mac_valid`=0, `mac_last`=0, `frame_err`=0. Counters and the delay pipeline are reset to 0.
- Line-buffer contents are not reset. Stale data is never emitted because of the `row`>=2 gate.
- Reset asserted mid-frame: all outputs drop asynchronously, and in-flight `mac_valid` pulses are discarded. The next accepted pixel is (0,0).

## Configuration
- Macro `SOF_RESYNC_EN`.
- Defined: a pixel accepted with `sof`=1 is treated as (0,0).
  - If the counters were not already at (0,0), `frame_err` pulses at t+1.
  - Any window that would have issued for that pixel is suppressed.
- Undefined: `sof` is ignored; framing relies solely on the counters, and `frame_err` is tied to 0.

## Test plan
- Ramp frame, pixel value = 28r+c, continuous `pix_valid`:
  - first `win_valid` one cycle after pixel 58, with halfwords [143:0] = 0,1,2,28,29,30,56,57,58;
  - exactly 676 windows;
  - `win_last` on the window ending 783.
- Same frame with random `pix_valid` gaps (~50% duty): identical window sequence and count; `win_data` stable across gaps.
- Reset after 100 pixels, then a full ramp frame: no output during or after reset until pixel (2,2); 676 correct windows.
- Two back-to-back frames: the second frame's first window is at its pixel (2,2) with values 0..58 pattern; no windows mix frames; 1352 total.
- `mac_valid` alignment: each `mac_valid` is exactly 3 cycles after its `win_valid`; `mac_last` is 3 cycles after `win_last`.
- With `SOF_RESYNC_EN`, `sof` asserted on pixel 300: `frame_err` pulses once, counters restart, and a full 676-window frame follows. Without the macro: no `frame_err`, and windows continue on the original count.

Source files
------------

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: 3x3 sliding-window generator over a raster pixel stream.
// Optional macro SOF_RESYNC_EN: sof forces the accepted pixel to (0,0) and pulses frame_err.
module conv_window_buffer #(
    parameter int PIX_BITS = 16,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int MAC_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_BITS-1:0]   pix_in,
    input  logic                  pix_valid,
    input  logic                  sof,
    output logic [9*PIX_BITS-1:0] win_data,
    output logic                  win_valid,
    output logic                  win_last,
    output logic                  mac_valid,
    output logic                  mac_last,
    output logic                  frame_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int P  = PIX_BITS;

    logic [CW-1:0]      col;
    logic [CW-1:0]      pos_col;
    logic [CW-1:0]      nxt_col;
    logic [RW-1:0]      row;
    logic [RW-1:0]      pos_row;
    logic [RW-1:0]      nxt_row;
    logic [P-1:0]       lb1 [IMG_W];
    logic [P-1:0]       lb2 [IMG_W];
    logic [P-1:0]       lb1_rd;
    logic [P-1:0]       lb2_rd;
    logic               resync;
    logic               win_hit;
    logic               last_hit;
    logic [MAC_LAT-1:0] vpipe;
    logic [MAC_LAT-1:0] lpipe;

`ifdef SOF_RESYNC_EN
    logic at_origin;
    assign at_origin = (col == '0) && (row == '0);
    assign resync    = pix_valid && sof;
`else
    logic unused_sof;
    assign unused_sof = sof;
    assign resync     = 1'b0;
`endif

    // Effective position of the accepted pixel and the position after it
    always_comb begin
        pos_col = col;
        pos_row = row;
        if (resync) begin
            pos_col = '0;
            pos_row = '0;
        end
        nxt_col = pos_col + 1'b1;
        nxt_row = pos_row;
        if (pos_col == CW'(IMG_W - 1)) begin
            nxt_col = '0;
            if (pos_row == RW'(IMG_H - 1)) begin
                nxt_row = '0;
            end else begin
                nxt_row = pos_row + 1'b1;
            end
        end
    end

    assign lb1_rd   = lb1[pos_col];
    assign lb2_rd   = lb2[pos_col];
    assign win_hit  = pix_valid && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    assign last_hit = win_hit && (pos_row == RW'(IMG_H - 1))
                      && (pos_col == CW'(IMG_W - 1));

    // Raster position counters advance on each accepted pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Line buffers: row r-1 cascades into row r-2, read before write
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2[pos_col] <= lb1_rd;
            lb1[pos_col] <= pix_in;
        end
    end

    // Window shifts left and takes the new right column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_data  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= win_hit;
            win_last  <= last_hit;
            if (pix_valid) begin
                win_data <= {win_data[8*P-1:6*P], lb2_rd,
                             win_data[5*P-1:3*P], lb1_rd,
                             win_data[2*P-1:0],   pix_in};
            end
        end
    end

    // Delay strobes to line up with the MAC result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= win_valid;
            lpipe[0] <= win_last;
            for (int i = 1; i < MAC_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    assign mac_valid = vpipe[MAC_LAT-1];
    assign mac_last  = lpipe[MAC_LAT-1];

`ifdef SOF_RESYNC_EN
    // Flag a sof that arrives when the counters are not at frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= resync && !at_origin;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
